// File: rtl/jtframe_dwnld_if.sv
// ioctl download stream in, SDRAM/PROM programming writes out.
// master drives the download stream and acknowledge; slave is the converter.
interface jtframe_dwnld_if;
    logic        downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        sdram_ack;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prom_we;
    logic        dwnld_busy;
    logic        dwnld_done;
    logic        overrun;

    modport master (
        output downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
        input  prog_addr, prog_data, prog_mask, prog_we, prom_we,
               dwnld_busy, dwnld_done, overrun
    );

    modport slave (
        input  downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
        output prog_addr, prog_data, prog_mask, prog_we, prom_we,
               dwnld_busy, dwnld_done, overrun
    );
endinterface

// File: rtl/jtframe_dwnld.sv
// Byte-wide ioctl download to SDRAM word writes / PROM byte pulses,
// with a one-entry skid buffer covering SDRAM acknowledge latency.
module jtframe_dwnld #(
    parameter logic [21:0] PROM_START = 22'h3F_0000,
    parameter logic        SWAB       = 1'b0
) (
    input logic            clk,
    input logic            rst,
    jtframe_dwnld_if.slave bus
);

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t      state;

    logic        buf_full;
    logic        buf_prom;
    logic [21:0] buf_addr;
    logic [7:0]  buf_data;

    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prom_we;
    logic        dwnld_busy;
    logic        dwnld_done;
    logic        overrun;

    logic        strobe;
    logic        new_prom;
    logic        pop;
    logic        direct;
    logic        push;
    logic        drop;
    logic        issue;
    logic [21:0] iss_addr;
    logic [7:0]  iss_data;
    logic        iss_prom;
    logic [21:0] dec_addr;
    logic [1:0]  dec_mask;
    logic        busy_next;

    // A buffered byte always goes out before the incoming one, so ordering
    // holds; a new strobe can refill the entry on the same edge it drains.
    always_comb begin
        strobe   = bus.downloading & bus.ioctl_wr;
        new_prom = bus.ioctl_addr >= PROM_START;
        pop      = buf_full & ((state == IDLE) | bus.sdram_ack);
        direct   = strobe & (state == IDLE) & ~buf_full;
        push     = strobe & ~direct & (~buf_full | pop);
        drop     = strobe & ~direct & buf_full & ~pop;
        issue    = pop | direct;

        iss_addr = pop ? buf_addr : bus.ioctl_addr;
        iss_data = pop ? buf_data : bus.ioctl_data;
        iss_prom = pop ? buf_prom : new_prom;

        if (iss_prom) begin
            dec_addr = iss_addr - PROM_START;
            dec_mask = 2'b11;
        end else begin
            dec_addr = {1'b0, iss_addr[21:1]};
            dec_mask = (iss_addr[0] ^ SWAB) ? 2'b01 : 2'b10;
        end

        busy_next = bus.downloading | (state != IDLE) | buf_full;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            prog_addr  <= '0;
            prog_data  <= '0;
            prog_mask  <= '1;
            prog_we    <= 1'b0;
            prom_we    <= 1'b0;
            dwnld_busy <= 1'b0;
            dwnld_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            prom_we    <= 1'b0;
            dwnld_busy <= busy_next;
            dwnld_done <= dwnld_busy & ~busy_next;
            if (drop) overrun <= 1'b1;

            // issue is only ever true in IDLE or on an acknowledged WAIT_ACK edge
            if (issue) begin
                prog_addr <= dec_addr;
                prog_data <= iss_data;
                prog_mask <= dec_mask;
                prog_we   <= ~iss_prom;
                prom_we   <= iss_prom;
                state     <= iss_prom ? IDLE : WAIT_ACK;
            end else if (state == WAIT_ACK && bus.sdram_ack) begin
                prog_we <= 1'b0;
                state   <= IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full <= 1'b0;
            buf_prom <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else if (push) begin
            buf_full <= 1'b1;
            buf_prom <= new_prom;
            buf_addr <= bus.ioctl_addr;
            buf_data <= bus.ioctl_data;
        end else if (pop) begin
            buf_full <= 1'b0;
        end
    end

    assign bus.prog_addr  = prog_addr;
    assign bus.prog_data  = prog_data;
    assign bus.prog_mask  = prog_mask;
    assign bus.prog_we    = prog_we;
    assign bus.prom_we    = prom_we;
    assign bus.dwnld_busy = dwnld_busy;
    assign bus.dwnld_done = dwnld_done;
    assign bus.overrun    = overrun;

endmodule

// File: tb/tb_jtframe_dwnld.sv
// Directed bench for jtframe_dwnld: expected writes are queued at stimulus
// time and matched by a monitor whenever a new prog/prom write appears.
module tb_jtframe_dwnld;

    typedef struct {
        logic        prom;
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   run_len;
    int   last_run;
    int   done_cnt;
    logic prev_we;
    logic prev_acc;
    exp_t exp_q[$];

    jtframe_dwnld_if bus();
    jtframe_dwnld_if bus2();

    jtframe_dwnld #(.PROM_START(22'h3F_0000), .SWAB(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    jtframe_dwnld #(.PROM_START(22'h3F_0000), .SWAB(1'b1)) dut_swab (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    assign bus2.downloading = bus.downloading;
    assign bus2.ioctl_addr  = bus.ioctl_addr;
    assign bus2.ioctl_data  = bus.ioctl_data;
    assign bus2.ioctl_wr    = bus.ioctl_wr;
    assign bus2.sdram_ack   = bus.sdram_ack;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic expect_wr(input logic prom, input logic [21:0] addr,
                             input logic [7:0] data, input logic [1:0] mask);
        exp_t e;
        e.prom = prom;
        e.addr = addr;
        e.data = data;
        e.mask = mask;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [21:0] addr, input logic [7:0] data);
        bus.ioctl_addr = addr;
        bus.ioctl_data = data;
        bus.ioctl_wr   = 1'b1;
        @(posedge clk);
        #1;
        bus.ioctl_wr   = 1'b0;
    endtask

    // ack is raised after k edges and sampled on the edge that follows
    task automatic ack_after(input int k);
        cycles(k);
        bus.sdram_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.sdram_ack = 1'b0;
    endtask

    // Monitor: a new SDRAM write is prog_we rising or prog_we held across an ack.
    always @(negedge clk) begin
        if (rst) begin
            prev_we  = 1'b0;
            prev_acc = 1'b0;
            run_len  = 0;
        end else begin
            if (bus.prom_we === 1'b1) compare_out(1'b1);
            if (bus.prog_we === 1'b1 && (!prev_we || prev_acc)) compare_out(1'b0);
            if (bus.prog_we === 1'b1) run_len++;
            else if (run_len > 0) begin
                last_run = run_len;
                run_len  = 0;
            end
            if (bus.dwnld_done === 1'b1) done_cnt++;
            prev_acc = bus.prog_we & bus.sdram_ack;
            prev_we  = bus.prog_we;
        end
    end

    task automatic compare_out(input logic prom);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got prom=%0b addr=%0h data=%0h, expected none",
                     prom, bus.prog_addr, bus.prog_data);
        end else begin
            e = exp_q.pop_front();
            if (e.prom !== prom || e.addr !== bus.prog_addr ||
                e.data !== bus.prog_data || e.mask !== bus.prog_mask) begin
                errors++;
                $display("FAIL write: got prom=%0b addr=%0h data=%0h mask=%0b, expected prom=%0b addr=%0h data=%0h mask=%0b",
                         prom, bus.prog_addr, bus.prog_data, bus.prog_mask,
                         e.prom, e.addr, e.data, e.mask);
            end
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        run_len  = 0;
        last_run = 0;
        done_cnt = 0;
        prev_we  = 1'b0;
        prev_acc = 1'b0;
        rst             = 1'b1;
        bus.downloading = 1'b0;
        bus.ioctl_addr  = '0;
        bus.ioctl_data  = '0;
        bus.ioctl_wr    = 1'b0;
        bus.sdram_ack   = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_prog_addr", 32'(bus.prog_addr), 32'h0);
        check("rst_prog_mask", 32'(bus.prog_mask), 32'h3);
        check("rst_prog_we",   32'(bus.prog_we),   32'h0);
        check("rst_prom_we",   32'(bus.prom_we),   32'h0);
        check("rst_busy",      32'(bus.dwnld_busy), 32'h0);
        check("rst_done",      32'(bus.dwnld_done), 32'h0);
        check("rst_overrun",   32'(bus.overrun),   32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single SDRAM byte, odd address -> high byte
        bus.downloading = 1'b1;
        cycles(2);
        check("busy_when_downloading", 32'(bus.dwnld_busy), 32'h1);
        expect_wr(1'b0, 22'h000001, 8'hA5, 2'b01);
        strobe(22'h000003, 8'hA5);
        ack_after(3);
        check("single_we_low_after_ack", 32'(bus.prog_we), 32'h0);
        cycles(2);
        check("single_we_length", 32'(last_run), 32'd4);

        // SWAB instance sees the same even address in the high byte
        expect_wr(1'b0, 22'h000002, 8'h77, 2'b10);
        strobe(22'h000004, 8'h77);
        check("swab_prog_addr", 32'(bus2.prog_addr), 32'h2);
        check("swab_prog_mask", 32'(bus2.prog_mask), 32'h1);
        check("swab_prog_we",   32'(bus2.prog_we),   32'h1);
        ack_after(1);
        cycles(2);

        // PROM byte: one-cycle prom_we, no SDRAM request
        expect_wr(1'b1, 22'h000005, 8'h3C, 2'b11);
        strobe(22'h3F0005, 8'h3C);
        check("prom_we_pulse", 32'(bus.prom_we), 32'h1);
        check("prom_no_prog_we", 32'(bus.prog_we), 32'h0);
        cycles(1);
        check("prom_we_cleared", 32'(bus.prom_we), 32'h0);
        check("prom_no_prog_we_later", 32'(bus.prog_we), 32'h0);
        cycles(2);

        // back-to-back: 0 issues, 1 buffered, 2 dropped
        expect_wr(1'b0, 22'h000000, 8'h11, 2'b10);
        expect_wr(1'b0, 22'h000000, 8'h22, 2'b01);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 22'h000000;
        bus.ioctl_data = 8'h11;
        cycles(1);
        bus.ioctl_addr = 22'h000001;
        bus.ioctl_data = 8'h22;
        cycles(1);
        bus.ioctl_addr = 22'h000002;
        bus.ioctl_data = 8'h33;
        cycles(1);
        bus.ioctl_wr   = 1'b0;
        check("overrun_set", 32'(bus.overrun), 32'h1);
        ack_after(8);
        check("b2b_second_pending", 32'(bus.prog_we), 32'h1);
        ack_after(2);
        cycles(2);
        check("b2b_we_low", 32'(bus.prog_we), 32'h0);
        check("overrun_sticky", 32'(bus.overrun), 32'h1);

        // end of download with a write pending
        expect_wr(1'b0, 22'h000008, 8'h5A, 2'b10);
        strobe(22'h000010, 8'h5A);
        bus.downloading = 1'b0;
        cycles(2);
        check("eod_busy_pending", 32'(bus.dwnld_busy), 32'h1);
        ack_after(3);
        check("eod_busy_after_ack", 32'(bus.dwnld_busy), 32'h1);
        check("eod_no_done_yet", 32'(bus.dwnld_done), 32'h0);
        cycles(1);
        check("eod_busy_fell", 32'(bus.dwnld_busy), 32'h0);
        check("eod_done_pulse", 32'(bus.dwnld_done), 32'h1);
        cycles(1);
        check("eod_done_cleared", 32'(bus.dwnld_done), 32'h0);
        cycles(2);
        check("eod_done_count", 32'(done_cnt), 32'd1);

        // reset mid-write discards the pending write and buffered byte
        bus.downloading = 1'b1;
        cycles(1);
        expect_wr(1'b0, 22'h000003, 8'h99, 2'b10);
        strobe(22'h000006, 8'h99);
        strobe(22'h000007, 8'hAA);
        strobe(22'h000008, 8'hBB);
        check("rst_test_overrun", 32'(bus.overrun), 32'h1);
        check("rst_test_we_high", 32'(bus.prog_we), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_prog_we", 32'(bus.prog_we), 32'h0);
        check("async_rst_overrun", 32'(bus.overrun), 32'h0);
        check("async_rst_mask",    32'(bus.prog_mask), 32'h3);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ack_after(1);
        cycles(3);
        check("post_rst_prog_we", 32'(bus.prog_we), 32'h0);
        check("post_rst_prom_we", 32'(bus.prom_we), 32'h0);
        bus.downloading = 1'b0;
        cycles(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
